shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier that sits directly upstream of the ripple-carry adder in the arithmetic datapath. It issues one operand pair per cycle to a W-bit adder slice and consumes the slice's sum and carry-out. Over W cycles it accumulates a 2W-bit product. Valid/ready handshakes on both input and output let it plug into the same datapath as the other arithmetic stages.

## Interface
- WIDTH, 4, operand width W in bits; product is 2W bits; legal range 2..16
- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, synchronous and active-low
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  block accepts an operand pair this cycle
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product is valid
- out_ready  input  1  downstream accepts the product this cycle
- product  output  2*WIDTH  a*b, unsigned, exact; no overflow is possible

## Operation
- States: IDLE, CALC, DONE; 2-bit encoding; reset state is IDLE.
- Registers:
  - mcand[W-1:0]
  - P[2W-1:0], where the upper half is the accumulator and the lower half is the remaining multiplier
  - cnt, sized to hold 0..W-1
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: mcand<=a, P<={W'b0, b}, cnt<=0, go to CALC.
- CALC (in_ready=0, out_valid=0), each cycle:
  - add_a=P[2W-1:W]; add_b = P[0] ? mcand : 0; adder carry-in fixed at 0.
  - {cout,sum} = add_a + add_b, W+1 bits.
  - P <= {cout, sum, P[W-1:1]}, i.e. the (2W+1)-bit value {cout,sum,P[W-1:0]} shifted right by 1.
  - cnt<=cnt+1. When cnt==W-1, go to DONE.
- DONE:
  - out_valid=1; product=P. product is held stable and in_valid is ignored while waiting.
  - On out_ready, go to IDLE.
- No same-cycle accept in DONE: in_ready stays 0 until the state is IDLE.
- product always drives P. It is don't-care when out_valid=0 but must not contain X after reset.
- Zero operands take the full W cycles; there is no early termination.

## Timing
- Reset, while rst_n=0 at a rising edge:
  - state=IDLE, P=0, mcand=0, cnt=0.
  - out_valid=0, product=0.
  - in_ready is forced 0 while rst_n is low.
- Reset mid-operation: an in-flight computation is dropped and no out_valid is produced for it. in_ready=1 on the first cycle with rst_n=1.
- Latency:
  - Accept at edge E0. out_valid is high in the cycle after edge E0+W (W CALC cycles).
  - For WIDTH=4, out_valid rises 5 cycles after the accept edge.
- Throughput: at best one product per W+2 cycles (accept, W×CALC, DONE, back to IDLE).
- in_valid while in CALC or DONE is ignored. Upstream must hold its data; nothing is queued.
- out_ready held low: DONE and product are held indefinitely.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE/CALC/DONE)
  - the default WIDTH constant
  - the localparam for counter width, $clog2(WIDTH)
- Sub-module mul_adder_slice: W-bit ripple-carry adder built from one-bit full-adder cells.
  - Inputs x, y, and cin (tied 0). Outputs s and cout.
  - Purely combinational. Instantiated once; the block holds the control FSM and registers.

## Test plan
- Reset then 15×15, WIDTH=4: in_valid pulse → out_valid exactly 5 cycles after the accept edge, product=8'hE1 (225); in_ready=0 throughout CALC/DONE.
- 0×9 and 9×0 → product=8'h00 after the full 5-cycle latency; 13×11 → 8'h8F (143).
- Backpressure: 7×6 with out_ready held low 10 cycles → out_valid stays 1 and product=8'h2A stable; one out_ready cycle → IDLE, in_ready=1 the next cycle.
- Busy rejection: accept 3×5, then drive in_valid with 2×2 on every CALC cycle → product=8'h0F; 2×2 is never consumed, and in_valid must be re-presented in IDLE.
- Reset mid-operation: accept 12×12, assert rst_n=0 on the 2nd CALC cycle → the following cycle shows out_valid=0 and product=0, and no out_valid appears afterward.
- Exhaustive: all 256 pairs back-to-back with random out_ready stalls → every product matches the a*b reference model; count of accepted inputs equals count of outputs.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared types and constants for the shift-add multiplier
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/shift_add_multiplier_adder_slice.sv
// rtl/shift_add_multiplier_adder_slice.sv - W-bit ripple-carry adder built from full-adder cells
module mul_adder_slice #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] c;

  assign c[0] = cin;

  // One full-adder cell per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned shift-and-add multiplier with valid/ready
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH);

  mul_state_e           state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]     add_b;
  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  // Only add the multiplicand when the current multiplier LSB is set.
  assign add_b = p_q[0] ? mcand_q : '0;

  mul_adder_slice #(.WIDTH(WIDTH)) u_adder (
    .x    (p_q[2*WIDTH-1:WIDTH]),
    .y    (add_b),
    .cin  (1'b0),
    .s    (add_sum),
    .cout (add_cout)
  );

  // Handshake outputs decode registered state only; in_ready also drops while in reset.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = p_q;

  // Next-state and datapath update for the IDLE/CALC/DONE control sequence.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Shift {cout,sum,multiplier} right by one: accumulator grows down into the vacated bits.
        p_d   = {add_cout, add_sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] product;

  int vectors;
  int fails;
  int accepted;
  int produced;
  logic [7:0] exp_q[$];

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present a pair at a negedge and let the next rising edge accept it.
  task automatic accept(input logic [3:0] av, input logic [3:0] bv, input bit track);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    if (track) begin
      exp_q.push_back({4'b0, av} * {4'b0, bv});
      accepted++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called on the first negedge after the accept edge; counts negedges until out_valid.
  task automatic wait_valid(input bit chk_lat);
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      check("busy_in_ready", in_ready, 0);
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", out_valid, 1);
    check("busy_in_ready_done", in_ready, 0);
    if (chk_lat) check("latency", n, 5);
  endtask

  // Randomly stall out_ready; compare against the scoreboard on the handshake cycle.
  task automatic drain(input int stall_pct);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (n == 199) out_ready = 1'b1;
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_nonempty", 0, 1);
        end else begin
          check("product", product, exp_q.pop_front());
        end
        produced++;
        done = 1'b1;
      end else begin
        check("stall_out_valid", out_valid, 1);
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    vectors   = 0;
    fails     = 0;
    accepted  = 0;
    produced  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 8'h00);
    check("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);
    check("post_reset_out_valid", out_valid, 0);

    // 15 x 15, with exact latency.
    accept(4'd15, 4'd15, 1'b1);
    wait_valid(1'b1);
    drain(0);
    check("idle_in_ready", in_ready, 1);

    // Zero operands and a mixed pair, each with full latency.
    accept(4'd0, 4'd9, 1'b1);
    wait_valid(1'b1);
    drain(0);
    accept(4'd9, 4'd0, 1'b1);
    wait_valid(1'b1);
    drain(0);
    accept(4'd13, 4'd11, 1'b1);
    wait_valid(1'b1);
    drain(0);

    // Backpressure: hold out_ready low for 10 cycles.
    accept(4'd7, 4'd6, 1'b1);
    wait_valid(1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 8'h2A);
      check("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    drain(0);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);

    // Busy rejection: 2 x 2 offered throughout CALC and DONE is never taken.
    accept(4'd3, 4'd5, 1'b1);
    in_valid = 1'b1;
    a = 4'd2;
    b = 4'd2;
    wait_valid(1'b1);
    repeat (2) @(negedge clk);
    check("busy_hold_valid", out_valid, 1);
    in_valid = 1'b0;
    drain(0);
    check("busy_idle_ready", in_ready, 1);
    @(negedge clk);
    check("busy_not_consumed_ready", in_ready, 1);
    check("busy_not_consumed_valid", out_valid, 0);

    // Reset on the 2nd CALC cycle drops the computation.
    accept(4'd12, 4'd12, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_product", product, 8'h00);
    check("midreset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready_after", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      check("midreset_no_valid", out_valid, 0);
      @(negedge clk);
    end

    // Exhaustive sweep with random output stalls.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        accept(4'(i), 4'(j), 1'b1);
        wait_valid(1'b1);
        drain(40);
      end
    end
    check("accepted_eq_produced", produced, accepted);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
